// File: rtl/dbg_run_ctrl.sv
// Run-control sequencer for the DEBUG data register. It runs entirely in tck.
// Scanned commands are turned into a halt/step/resume handshake with the core.
module dbg_run_ctrl #(
    parameter int DR_W  = 16,
    parameter int CNT_W = 12
) (
    input  logic tck,
    input  logic trst,
    input  logic dbg_sel,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_dr,
    input  logic tdi,
    output logic tdo_dbg,
    input  logic cpu_halted,
    input  logic step_ack,
    output logic cpu_halt_req,
    output logic step_req,
    output logic busy,
    output logic err
);

    typedef enum logic [2:0] {
        ST_RUN         = 3'd0,
        ST_HALT_WAIT   = 3'd1,
        ST_HALTED      = 3'd2,
        ST_STEP_REQ    = 3'd3,
        ST_STEP_DONE   = 3'd4,
        ST_RESUME_WAIT = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_HALT    = 4'd1;
    localparam logic [3:0] OP_RESUME  = 4'd2;
    localparam logic [3:0] OP_STEP    = 4'd3;
    localparam logic [3:0] OP_CLR_ERR = 4'd4;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DR_W-1:0]   r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_halt_req;
    logic              r_step_req;
    logic              r_busy;
    logic              w_halt_req_nxt;
    logic              w_step_req_nxt;
    logic              w_busy_nxt;
    logic              w_update;
    logic              w_capture;
    logic              w_shift;
    logic              w_busy_now;
    logic              w_legal;
    logic [3:0]        w_op;
    logic [CNT_W-1:0]  w_arg;

    // Update outranks capture, and capture outranks shift, when strobes overlap.
    assign w_update  = dbg_sel & update_dr;
    assign w_capture = dbg_sel & capture_dr & ~update_dr;
    assign w_shift   = dbg_sel & shift_dr & ~update_dr & ~capture_dr;

    assign w_op       = r_sr[DR_W-1 -: 4];
    assign w_arg      = r_sr[CNT_W-1:0];
    assign w_legal    = (r_state <= ST_RESUME_WAIT);
    assign w_busy_now = (r_state == ST_HALT_WAIT) || (r_state == ST_STEP_REQ) ||
                        (r_state == ST_STEP_DONE) || (r_state == ST_RESUME_WAIT);

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_sr <= '0;
        end else if (w_capture) begin
            r_sr <= {r_state, r_err, r_cnt};
        end else if (w_shift) begin
            r_sr <= {tdi, r_sr[DR_W-1:1]};
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_halt_req <= 1'b0;
            r_step_req <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_halt_req <= w_halt_req_nxt;
            r_step_req <= w_step_req_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Handshake progress runs first, so a rejected command leaves it untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            ST_RUN:         ;
            ST_HALTED:      ;
            ST_HALT_WAIT:   if (cpu_halted) w_state_nxt = ST_HALTED;
            ST_STEP_REQ: begin
                if (step_ack) begin
                    w_state_nxt = ST_STEP_DONE;
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_STEP_DONE: begin
                if (!step_ack) w_state_nxt = (r_cnt != '0) ? ST_STEP_REQ : ST_HALTED;
            end
            ST_RESUME_WAIT: if (!cpu_halted) w_state_nxt = ST_RUN;
            default:        w_state_nxt = ST_RUN;
        endcase

        if (w_update) begin
            case (w_op)
                OP_NOP: ;
                OP_HALT: begin
                    if (w_busy_now)              w_err_nxt   = 1'b1;
                    else if (r_state == ST_RUN)  w_state_nxt = ST_HALT_WAIT;
                end
                OP_RESUME: begin
                    if (w_busy_now)                 w_err_nxt   = 1'b1;
                    else if (r_state == ST_HALTED)  w_state_nxt = ST_RESUME_WAIT;
                end
                OP_STEP: begin
                    if (w_busy_now || r_state == ST_RUN) begin
                        w_err_nxt = 1'b1;
                    end else if (r_state == ST_HALTED) begin
                        w_cnt_nxt = w_arg;
                        if (w_arg != '0) w_state_nxt = ST_STEP_REQ;
                    end
                end
                OP_CLR_ERR: w_err_nxt = 1'b0;
                default:    w_err_nxt = 1'b1;
            endcase
        end

        if (!w_legal) w_err_nxt = 1'b1;
    end

    always_comb begin
        w_halt_req_nxt = (w_state_nxt == ST_HALT_WAIT) || (w_state_nxt == ST_HALTED) ||
                         (w_state_nxt == ST_STEP_REQ)  || (w_state_nxt == ST_STEP_DONE);
        w_step_req_nxt = (w_state_nxt == ST_STEP_REQ);
        w_busy_nxt     = (w_state_nxt == ST_HALT_WAIT) || (w_state_nxt == ST_STEP_REQ) ||
                         (w_state_nxt == ST_STEP_DONE) || (w_state_nxt == ST_RESUME_WAIT);
    end

    assign tdo_dbg      = r_sr[0];
    assign cpu_halt_req = r_halt_req;
    assign step_req     = r_step_req;
    assign busy         = r_busy;
    assign err          = r_err;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl: directed scenarios plus a random command stream.
// A transaction-level model of the run-control rules supplies the expected status.
module tb_dbg_run_ctrl;

    localparam int S_RUN         = 0;
    localparam int S_HALT_WAIT   = 1;
    localparam int S_HALTED      = 2;
    localparam int S_STEP_REQ    = 3;
    localparam int S_RESUME_WAIT = 5;

    logic tck = 1'b0;
    logic trst, dbg_sel, capture_dr, shift_dr, update_dr, tdi;
    logic cpu_halted, step_ack;
    logic tdo_dbg, cpu_halt_req, step_req, busy, err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    int          mState;
    logic        mErr;
    logic [11:0] mCnt;

    logic [15:0] dout;

    dbg_run_ctrl dut (
        .tck(tck), .trst(trst), .dbg_sel(dbg_sel), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr), .tdi(tdi), .tdo_dbg(tdo_dbg),
        .cpu_halted(cpu_halted), .step_ack(step_ack), .cpu_halt_req(cpu_halt_req),
        .step_req(step_req), .busy(busy), .err(err)
    );

    always #5 tck = ~tck;

    always @(posedge step_req) pulses++;

    // Core model: acks two cycles into a request and releases one cycle after it drops.
    initial begin
        int reqAge;
        int dropAge;
        reqAge   = 0;
        dropAge  = 0;
        step_ack = 1'b0;
        forever begin
            @(posedge tck);
            #1;
            if (step_req && !step_ack) begin
                reqAge++;
                if (reqAge >= 2) step_ack = 1'b1;
            end else reqAge = 0;
            if (!step_req && step_ack) begin
                dropAge++;
                if (dropAge >= 1) step_ack = 1'b0;
            end else dropAge = 0;
        end
    end

    task automatic cyc();
        @(posedge tck);
        #1;
    endtask

    function automatic logic [15:0] modelStatus();
        logic [2:0] st;
        st = 3'(mState);
        return {st, mErr, mCnt};
    endfunction

    function automatic void modelCmd(input logic [15:0] cmd);
        int  op;
        bit  isBusy;
        op     = int'(cmd[15:12]);
        isBusy = (mState == S_HALT_WAIT) || (mState == S_STEP_REQ) || (mState == 4) ||
                 (mState == S_RESUME_WAIT);
        case (op)
            0: ;
            1: if (isBusy) mErr = 1'b1; else if (mState == S_RUN) mState = S_HALT_WAIT;
            2: if (isBusy) mErr = 1'b1; else if (mState == S_HALTED) mState = S_RESUME_WAIT;
            3: begin
                if (isBusy || mState == S_RUN) mErr = 1'b1;
                else begin
                    mCnt = cmd[11:0];
                    if (mCnt != 0) mState = S_STEP_REQ;
                end
            end
            4: mErr = 1'b0;
            default: mErr = 1'b1;
        endcase
    endfunction

    task automatic scanDr(input logic [15:0] din, output logic [15:0] got);
        dbg_sel    = 1'b1;
        capture_dr = 1'b1;
        cyc();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tdi    = din[i];
            got[i] = tdo_dbg;
            cyc();
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        cyc();
        update_dr = 1'b0;
        dbg_sel   = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc, input string tag);
        int n;
        n = 0;
        while (busy && n < maxCyc) begin
            cyc();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("[TB] FAIL %s: busy still %b after %0d cycles, expected 0", tag, busy, n);
            errors++;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        logic expHalt;
        expHalt = (mState == S_HALTED);
        checks++;
        if (cpu_halt_req !== expHalt || step_req !== 1'b0 || busy !== 1'b0 || err !== mErr) begin
            $display("[TB] FAIL %s: halt_req/step_req/busy/err = %b%b%b%b expected %b00%b",
                     tag, cpu_halt_req, step_req, busy, err, expHalt, mErr);
            errors++;
        end
    endtask

    // Issue a command, check the status captured before it, then let the core finish.
    task automatic doCmd(input logic [15:0] cmd, input string tag);
        int pulseBase;
        int expPulses;
        pulseBase = pulses;
        scanDr(cmd, dout);
        checks++;
        if (dout !== modelStatus()) begin
            $display("[TB] FAIL %s status: got %h expected %h", tag, dout, modelStatus());
            errors++;
        end
        modelCmd(cmd);
        case (mState)
            S_HALT_WAIT: begin
                repeat ($urandom_range(0, 3)) cyc();
                cpu_halted = 1'b1;
                waitIdle(20, tag);
                mState = S_HALTED;
            end
            S_RESUME_WAIT: begin
                repeat ($urandom_range(0, 3)) cyc();
                cpu_halted = 1'b0;
                waitIdle(20, tag);
                mState = S_RUN;
            end
            S_STEP_REQ: begin
                expPulses = int'(mCnt);
                waitIdle(40 + 6 * expPulses, tag);
                checks++;
                if (pulses - pulseBase !== expPulses) begin
                    $display("[TB] FAIL %s pulses: got %0d expected %0d", tag, pulses - pulseBase, expPulses);
                    errors++;
                end
                mState = S_HALTED;
                mCnt   = '0;
            end
            default: ;
        endcase
        checkIdleOutputs(tag);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        logic [15:0] got;
        {dbg_sel, capture_dr, shift_dr, update_dr, tdi, cpu_halted} = '0;
        trst = 1'b1;
        #2 trst = 1'b0;
        #3;
        mState = S_RUN;
        mErr   = 1'b0;
        mCnt   = '0;
        checks++;
        if ({tdo_dbg, cpu_halt_req, step_req, busy, err} !== 5'b0) begin
            $display("[TB] FAIL reset outputs: got %b expected 00000",
                     {tdo_dbg, cpu_halt_req, step_req, busy, err});
            errors++;
        end
        cyc();
        cyc();
        trst = 1'b1;
        cyc();
        scanDr(16'h0000, dout);
        checks++;
        if (dout !== 16'h0000) begin
            $display("[TB] FAIL reset status: got %h expected 0000", dout);
            errors++;
        end
        checkIdleOutputs("reset idle");

        v = 16'($urandom);
        dbg_sel  = 1'b1;
        shift_dr = 1'b1;
        for (int i = 0; i < 16; i++) begin tdi = v[i]; cyc(); end
        for (int i = 0; i < 16; i++) begin got[i] = tdo_dbg; tdi = 1'b0; cyc(); end
        checks++;
        if (got !== v) begin
            $display("[TB] FAIL shift path: got %h expected %h", got, v);
            errors++;
        end

        v = 16'h1000;
        for (int i = 0; i < 16; i++) begin tdi = v[i]; cyc(); end
        shift_dr   = 1'b0;
        dbg_sel    = 1'b0;
        update_dr  = 1'b1;
        capture_dr = 1'b1;
        cyc();
        update_dr  = 1'b0;
        capture_dr = 1'b0;
        checks++;
        if (cpu_halt_req !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL deselected update: halt_req %b busy %b expected 0 0", cpu_halt_req, busy);
            errors++;
        end
        dbg_sel  = 1'b1;
        shift_dr = 1'b1;
        for (int i = 0; i < 16; i++) begin got[i] = tdo_dbg; cyc(); end
        shift_dr = 1'b0;
        dbg_sel  = 1'b0;
        checks++;
        if (got !== v) begin
            $display("[TB] FAIL deselected capture: sr %h expected %h", got, v);
            errors++;
        end
    endtask

    task automatic test_halt();
        bit dropped;
        scanDr(16'h1000, dout);
        checks++;
        if (dout !== modelStatus()) begin
            $display("[TB] FAIL halt pre-status: got %h expected %h", dout, modelStatus());
            errors++;
        end
        modelCmd(16'h1000);
        checks++;
        if (cpu_halt_req !== 1'b1 || busy !== 1'b1) begin
            $display("[TB] FAIL halt latency: halt_req %b busy %b expected 1 1", cpu_halt_req, busy);
            errors++;
        end
        dropped = 1'b0;
        repeat (3) begin
            cyc();
            if (busy !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin
            $display("[TB] FAIL halt wait: busy dropped before cpu_halted, expected 1");
            errors++;
        end
        cpu_halted = 1'b1;
        cyc();
        mState = S_HALTED;
        checks++;
        if (busy !== 1'b0 || cpu_halt_req !== 1'b1) begin
            $display("[TB] FAIL halted edge: busy %b halt_req %b expected 0 1", busy, cpu_halt_req);
            errors++;
        end
        doCmd(16'h0000, "halted status");
    endtask

    task automatic test_step();
        int  pulseBase;
        int  n;
        bit  haltDrop;
        pulseBase = pulses;
        scanDr(16'h3003, dout);
        modelCmd(16'h3003);
        checks++;
        if (step_req !== 1'b1 || cpu_halt_req !== 1'b1) begin
            $display("[TB] FAIL step start: step_req %b halt_req %b expected 1 1", step_req, cpu_halt_req);
            errors++;
        end
        haltDrop = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
            if (cpu_halt_req !== 1'b1) haltDrop = 1'b1;
        end
        checks++;
        if (busy !== 1'b0 || haltDrop) begin
            $display("[TB] FAIL step run: busy %b halt_drop %b expected 0 0", busy, haltDrop);
            errors++;
        end
        checks++;
        if (pulses - pulseBase !== 3) begin
            $display("[TB] FAIL step pulses: got %0d expected 3", pulses - pulseBase);
            errors++;
        end
        mState = S_HALTED;
        mCnt   = '0;
        doCmd(16'h0000, "post-step status");
    endtask

    task automatic test_err_busy();
        int pulseBase;
        pulseBase = pulses;
        scanDr(16'h3020, dout);
        modelCmd(16'h3020);
        scanDr(16'h1000, dout);
        checks++;
        if (dout !== modelStatus()) begin
            $display("[TB] FAIL live capture: got %h expected %h", dout, modelStatus());
            errors++;
        end
        modelCmd(16'h1000);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            $display("[TB] FAIL busy halt err: err %b busy %b expected 1 1", err, busy);
            errors++;
        end
        scanDr(16'h4000, dout);
        checks++;
        if (dout[12] !== 1'b1 || !(dout[15:13] == 3'd3 || dout[15:13] == 3'd4) ||
            dout[11:0] >= 12'h020) begin
            $display("[TB] FAIL mid-step capture: got %h expected err=1 state 3/4 cnt<20", dout);
            errors++;
        end
        modelCmd(16'h4000);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            $display("[TB] FAIL clr_err: err %b busy %b expected 0 1", err, busy);
            errors++;
        end
        waitIdle(300, "err-step finish");
        checks++;
        if (pulses - pulseBase !== 32) begin
            $display("[TB] FAIL err-step pulses: got %0d expected 32", pulses - pulseBase);
            errors++;
        end
        mState = S_HALTED;
        mCnt   = '0;
        checkIdleOutputs("err-step idle");
    endtask

    task automatic test_cmd_sweep();
        int pulseBase;
        doCmd(16'h2000, "resume to run");
        doCmd(16'h3005, "step in run");
        checks++;
        if (err !== 1'b1) begin
            $display("[TB] FAIL step-in-run err: got %b expected 1", err);
            errors++;
        end
        doCmd(16'hF000, "illegal op");
        doCmd(16'h1000, "halt again");
        pulseBase = pulses;
        doCmd(16'h3000, "step zero");
        repeat (5) cyc();
        checks++;
        if (pulses - pulseBase !== 0 || step_req !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL step zero: pulses %0d step_req %b busy %b expected 0 0 0",
                     pulses - pulseBase, step_req, busy);
            errors++;
        end
        doCmd(16'h4000, "clear err");
    endtask

    task automatic test_resume_trst();
        bit dropped;
        int n;
        scanDr(16'h2000, dout);
        modelCmd(16'h2000);
        checks++;
        if (busy !== 1'b1 || cpu_halt_req !== 1'b0) begin
            $display("[TB] FAIL resume wait: busy %b halt_req %b expected 1 0", busy, cpu_halt_req);
            errors++;
        end
        dropped = 1'b0;
        repeat (4) begin
            cyc();
            if (busy !== 1'b1 || cpu_halt_req !== 1'b0) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin
            $display("[TB] FAIL resume hold: left RESUME_WAIT while cpu_halted=1, expected hold");
            errors++;
        end
        cpu_halted = 1'b0;
        cyc();
        mState = S_RUN;
        checks++;
        if (busy !== 1'b0) begin
            $display("[TB] FAIL resume edge: busy %b expected 0", busy);
            errors++;
        end
        doCmd(16'h0000, "after resume");

        doCmd(16'h1000, "halt for trst");
        scanDr(16'h3003, dout);
        n = 0;
        while (step_req !== 1'b1 && n < 10) begin cyc(); n++; end
        #2 trst = 1'b0;
        #1;
        checks++;
        if ({tdo_dbg, cpu_halt_req, step_req, busy, err} !== 5'b0) begin
            $display("[TB] FAIL async trst: got %b expected 00000",
                     {tdo_dbg, cpu_halt_req, step_req, busy, err});
            errors++;
        end
        #5 trst = 1'b1;
        cpu_halted = 1'b0;
        mState = S_RUN;
        mErr   = 1'b0;
        mCnt   = '0;
        cyc();
        doCmd(16'h0000, "post-trst status");
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [11:0] arg;
        for (int k = 0; k < 40; k++) begin
            op  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
            arg = (op == 4'd3 && mState == S_HALTED) ? 12'($urandom_range(0, 5)) : 12'($urandom);
            doCmd({op, arg}, "random");
        end
        doCmd(16'h0000, "random final");
    endtask

    initial begin
        test_reset();
        test_halt();
        test_step();
        test_err_busy();
        test_cmd_sweep();
        test_resume_trst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
